// File: rtl/text_term.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : text_term
//  Purpose  : Text-mode terminal character buffer. Accepts ASCII bytes over a
//             valid/ready handshake, keeps a COLS x ROWS screen with cursor,
//             handles CR/LF/BS/FF, line wrap and ring-buffer scrolling, and
//             offers a registered read port for the glyph renderer.
//  Revision : 1.0 - initial release
// ============================================================================
module text_term #(
    parameter int COLS = 70,
    parameter int ROWS = 30,
    parameter int XW   = 7,
    parameter int YW   = 5
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    input  logic [XW-1:0] rd_x,
    input  logic [YW-1:0] rd_y,
    output logic [7:0]    rd_ascii,
    output logic          rd_cursor,
    output logic [XW-1:0] cur_x,
    output logic [YW-1:0] cur_y,
    output logic          busy
);

    localparam int CELLS = COLS * ROWS;
    localparam int AW    = (CELLS > 1) ? $clog2(CELLS) : 1;

    localparam logic [1:0] S_INIT_CLR   = 2'd0;
    localparam logic [1:0] S_IDLE       = 2'd1;
    localparam logic [1:0] S_SCROLL_CLR = 2'd2;

    localparam logic [7:0]    c_SPACE     = 8'h20;
    localparam logic [7:0]    c_LF        = 8'h0A;
    localparam logic [7:0]    c_CR        = 8'h0D;
    localparam logic [7:0]    c_BS        = 8'h08;
    localparam logic [7:0]    c_FF        = 8'h0C;
    localparam logic [XW-1:0] c_COL_LAST  = XW'(COLS - 1);
    localparam logic [YW-1:0] c_ROW_LAST  = YW'(ROWS - 1);
    localparam logic [YW:0]   c_ROWS_X    = (YW+1)'(ROWS);
    localparam logic [AW-1:0] c_CELL_LAST = AW'(CELLS - 1);
    localparam logic [AW-1:0] c_COL_LASTA = AW'(COLS - 1);

    // (a + b) mod ROWS for two in-range row values, compare-and-wrap
    function automatic logic [YW-1:0] f_wrap(input logic [YW-1:0] a, input logic [YW-1:0] b);
        logic [YW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= c_ROWS_X) s = s - c_ROWS_X;
        return s[YW-1:0];
    endfunction

    // Linear cell index of a physical (row, column)
    function automatic logic [AW-1:0] f_addr(input logic [YW-1:0] row, input logic [AW-1:0] col);
        return AW'(row) * AW'(COLS) + col;
    endfunction

    logic [7:0]    r_mem [0:CELLS-1];

    logic [1:0]    r_state, w_state_nxt;
    logic [XW-1:0] r_cur_x, w_cur_x_nxt;
    logic [YW-1:0] r_cur_y, w_cur_y_nxt;
    logic [YW-1:0] r_top, w_top_nxt;
    logic [YW-1:0] r_clr_row, w_clr_row_nxt;
    logic [AW-1:0] r_cnt, w_cnt_nxt;

    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [7:0]    w_wdata;

    logic          w_acc;
    logic          w_printable;
    logic          w_eol;
    logic          w_bottom;
    logic          w_nl;
    logic [YW-1:0] w_prow;
    logic [YW-1:0] w_top_inc;
    logic          w_rd_in;
    logic [AW-1:0] w_raddr;

    assign w_acc       = in_valid && (r_state == S_IDLE);
    assign w_printable = (in_data >= 8'h20) && (in_data <= 8'h7E);
    assign w_eol       = (r_cur_x == c_COL_LAST);
    assign w_bottom    = (r_cur_y == c_ROW_LAST);
    // Newline comes from LF or from printing into the last column
    assign w_nl        = w_acc && ((w_printable && w_eol) || (in_data == c_LF));
    assign w_prow      = f_wrap(r_cur_y, r_top);
    assign w_top_inc   = (r_top == c_ROW_LAST) ? '0 : r_top + 1'b1;
    assign w_rd_in     = (rd_x <= c_COL_LAST) && (rd_y <= c_ROW_LAST);
    assign w_raddr     = f_addr(f_wrap(rd_y, r_top), AW'(rd_x));

    assign cur_x = r_cur_x;
    assign cur_y = r_cur_y;

    // State and datapath registers; reset restarts the full-screen clear
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_INIT_CLR;
            r_cur_x   <= '0;
            r_cur_y   <= '0;
            r_top     <= '0;
            r_clr_row <= '0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cur_x   <= w_cur_x_nxt;
            r_cur_y   <= w_cur_y_nxt;
            r_top     <= w_top_nxt;
            r_clr_row <= w_clr_row_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    // Next-state selection
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_INIT_CLR: begin
                if (r_cnt == c_CELL_LAST) w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (w_acc) begin
                    if (in_data == c_FF)          w_state_nxt = S_INIT_CLR;
                    else if (w_nl && w_bottom)    w_state_nxt = S_SCROLL_CLR;
                end
            end
            S_SCROLL_CLR: begin
                if (r_cnt == c_COL_LASTA) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_INIT_CLR;
        endcase
    end

    // Handshake, buffer write port and cursor/scroll bookkeeping
    always_comb begin
        in_ready      = (r_state == S_IDLE);
        busy          = (r_state != S_IDLE);
        w_cur_x_nxt   = r_cur_x;
        w_cur_y_nxt   = r_cur_y;
        w_top_nxt     = r_top;
        w_clr_row_nxt = r_clr_row;
        w_cnt_nxt     = r_cnt;
        w_we          = 1'b0;
        w_waddr       = r_cnt;
        w_wdata       = c_SPACE;
        case (r_state)
            S_INIT_CLR: begin
                w_we      = 1'b1;
                w_waddr   = r_cnt;
                w_cnt_nxt = r_cnt + 1'b1;
            end
            S_SCROLL_CLR: begin
                w_we      = 1'b1;
                w_waddr   = f_addr(r_clr_row, r_cnt);
                w_cnt_nxt = r_cnt + 1'b1;
            end
            S_IDLE: begin
                if (in_valid) begin
                    if (w_printable) begin
                        w_we    = 1'b1;
                        w_waddr = f_addr(w_prow, AW'(r_cur_x));
                        w_wdata = in_data;
                        if (!w_eol) w_cur_x_nxt = r_cur_x + 1'b1;
                    end else begin
                        case (in_data)
                            c_CR: w_cur_x_nxt = '0;
                            c_BS: begin
                                // No reverse wrap: BS at column 0 does nothing
                                if (r_cur_x != '0) begin
                                    w_cur_x_nxt = r_cur_x - 1'b1;
                                    w_we        = 1'b1;
                                    w_waddr     = f_addr(w_prow, AW'(r_cur_x - 1'b1));
                                end
                            end
                            c_FF: begin
                                w_cur_x_nxt = '0;
                                w_cur_y_nxt = '0;
                                w_top_nxt   = '0;
                                w_cnt_nxt   = '0;
                            end
                            default: ;
                        endcase
                    end
                    if (w_nl) begin
                        w_cur_x_nxt = '0;
                        if (!w_bottom) begin
                            w_cur_y_nxt = r_cur_y + 1'b1;
                        end else begin
                            // Old top physical row becomes the new bottom row
                            w_top_nxt     = w_top_inc;
                            w_clr_row_nxt = r_top;
                            w_cnt_nxt     = '0;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    // Character storage write port
    always_ff @(posedge clock) begin
        if (w_we) r_mem[w_waddr] <= w_wdata;
    end

    // Registered read port; reads see the pre-edge contents and cursor
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ascii  <= c_SPACE;
            rd_cursor <= 1'b0;
        end else begin
            rd_ascii  <= w_rd_in ? r_mem[w_raddr] : c_SPACE;
            rd_cursor <= w_rd_in && (rd_x == r_cur_x) && (rd_y == r_cur_y);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_text_term.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_text_term
//  Purpose  : Directed bench for text_term (8x4 screen) with a logical-screen
//             model checked every cycle plus literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_text_term;

    localparam int COLS = 8;
    localparam int ROWS = 4;
    localparam int XW   = 4;
    localparam int YW   = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready;
    logic [XW-1:0] rd_x = '0;
    logic [YW-1:0] rd_y = '0;
    logic [7:0]    rd_ascii;
    logic          rd_cursor;
    logic [XW-1:0] cur_x;
    logic [YW-1:0] cur_y;
    logic          busy;

    text_term #(.COLS(COLS), .ROWS(ROWS), .XW(XW), .YW(YW)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .rd_x(rd_x), .rd_y(rd_y), .rd_ascii(rd_ascii), .rd_cursor(rd_cursor),
        .cur_x(cur_x), .cur_y(cur_y), .busy(busy)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int t_acc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- logical-screen model ----------------
    logic [7:0] scr [ROWS][COLS];
    int         mx, my, mbusy;
    logic [7:0] e_ascii;
    logic       e_cur;
    logic       e_valid;

    task automatic m_clear_all();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) scr[r][c] = 8'h20;
    endtask

    task automatic m_newline();
        mx = 0;
        if (my < ROWS - 1) begin
            my++;
        end else begin
            for (int r = 0; r < ROWS - 1; r++)
                for (int c = 0; c < COLS; c++) scr[r][c] = scr[r+1][c];
            for (int c = 0; c < COLS; c++) scr[ROWS-1][c] = 8'h20;
            mbusy = COLS;
        end
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_clear_all();
            mx = 0; my = 0; mbusy = COLS * ROWS;
            e_ascii = 8'h20; e_cur = 1'b0; e_valid = 1'b1;
        end else begin
            e_valid = (mbusy == 0);
            if (int'(rd_x) < COLS && int'(rd_y) < ROWS) begin
                e_ascii = scr[rd_y][rd_x];
                e_cur   = (int'(rd_x) == mx) && (int'(rd_y) == my);
            end else begin
                e_ascii = 8'h20;
                e_cur   = 1'b0;
            end
            if (mbusy > 0) begin
                mbusy--;
            end else if (in_valid) begin
                if (in_data >= 8'h20 && in_data <= 8'h7E) begin
                    scr[my][mx] = in_data;
                    if (mx == COLS - 1) m_newline();
                    else mx++;
                end else begin
                    case (in_data)
                        8'h0A: m_newline();
                        8'h0D: mx = 0;
                        8'h08: if (mx > 0) begin mx--; scr[my][mx] = 8'h20; end
                        8'h0C: begin mx = 0; my = 0; m_clear_all(); mbusy = COLS * ROWS; end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clock) begin
        if (!reset) begin
            chk("in_ready", int'(in_ready), int'(mbusy == 0));
            chk("busy", int'(busy), int'(mbusy != 0));
            chk("cur_x", int'(cur_x), mx);
            chk("cur_y", int'(cur_y), my);
            chk("rd_cursor", int'(rd_cursor), int'(e_cur));
            if (e_valid) chk("rd_ascii", int'(rd_ascii), int'(e_ascii));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [7:0] b);
        bit got;
        got = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clock);
            if (in_ready) got = 1'b1;
        end
        if (!got) begin
            n_vec++; n_err++;
            $display("FAIL send_timeout: byte %02h not accepted, in_ready %0b required 1", b, in_ready);
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
        t_acc = cyc;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic rd(input int x, input int y, input int ea, input int ec, input string nm);
        rd_x = XW'(x);
        rd_y = YW'(y);
        @(posedge clock); #1;
        chk({nm, "_ascii"}, int'(rd_ascii), ea);
        chk({nm, "_cursor"}, int'(rd_cursor), ec);
    endtask

    task automatic low_cycles(output int n);
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_in_ready"}, int'(in_ready), 0);
        chk({nm, "_busy"}, int'(busy), 1);
        chk({nm, "_cur_x"}, int'(cur_x), 0);
        chk({nm, "_cur_y"}, int'(cur_y), 0);
        chk({nm, "_rd_ascii"}, int'(rd_ascii), 8'h20);
        chk({nm, "_rd_cursor"}, int'(rd_cursor), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, t1, t2, t3;

        // Reset and initial clear
        repeat (3) @(posedge clock);
        #1;
        chk_reset_vals("reset");
        reset = 1'b0;
        low_cycles(n);
        chk("init_clear_len", n, 32);
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++)
                rd(x, y, 8'h20, int'(x == 0 && y == 0), "blank");

        // Back-to-back printable stream
        send("A"); t1 = t_acc;
        send("B"); t2 = t_acc;
        send("C"); t3 = t_acc;
        chk("abc_gap1", t2 - t1, 1);
        chk("abc_gap2", t3 - t2, 1);
        chk("abc_cur_x", int'(cur_x), 3);
        rd(1, 0, 8'h42, 0, "abc_b");
        rd(3, 0, 8'h20, 1, "abc_cursor");

        // Line wrap
        send(8'h0C);
        for (int i = 0; i < 9; i++) send("x");
        chk("wrap_cur_x", int'(cur_x), 1);
        chk("wrap_cur_y", int'(cur_y), 1);
        for (int x = 0; x < COLS; x++) rd(x, 0, 8'h78, 0, "wrap_row0");
        rd(0, 1, 8'h78, 0, "wrap_r1c0");
        rd(1, 1, 8'h20, 1, "wrap_cursor");
        rd(8, 0, 8'h20, 0, "oob_x");
        rd(0, 4, 8'h20, 0, "oob_y");

        // Control codes
        send(8'h0C);
        send("A"); send("B"); send(8'h08);
        chk("bs_cur_x", int'(cur_x), 1);
        rd(1, 0, 8'h20, 1, "bs_erased");
        rd(0, 0, 8'h41, 0, "bs_kept");
        send(8'h0D);
        chk("cr_cur_x", int'(cur_x), 0);
        send(8'h08);
        chk("bs0_cur_x", int'(cur_x), 0);
        chk("bs0_cur_y", int'(cur_y), 0);
        rd(0, 0, 8'h41, 1, "bs0_cell");
        send(8'h07); send(8'h7F);
        chk("ign_cur_x", int'(cur_x), 0);
        chk("ign_cur_y", int'(cur_y), 0);
        rd(0, 0, 8'h41, 1, "ign_cell");
        send(8'h7E);
        chk("tilde_cur_x", int'(cur_x), 1);
        rd(0, 0, 8'h7E, 0, "tilde_cell");

        // Scroll
        send(8'h0C);
        send_str("0\n1\n2\n3");
        chk("pre_scroll_cur_y", int'(cur_y), 3);
        chk("pre_scroll_cur_x", int'(cur_x), 1);
        send(8'h0A);
        low_cycles(n);
        chk("scroll_len", n, 8);
        chk("scroll_cur_y", int'(cur_y), 3);
        chk("scroll_cur_x", int'(cur_x), 0);
        rd(0, 0, 8'h31, 0, "scroll_r0");
        rd(0, 1, 8'h32, 0, "scroll_r1");
        rd(0, 2, 8'h33, 0, "scroll_r2");
        for (int x = 0; x < COLS; x++) rd(x, 3, 8'h20, int'(x == 0), "scroll_r3");

        // Form feed
        send(8'h0C);
        low_cycles(n);
        chk("ff_len", n, 32);
        chk("ff_cur_x", int'(cur_x), 0);
        chk("ff_cur_y", int'(cur_y), 0);
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++)
                rd(x, y, 8'h20, int'(x == 0 && y == 0), "ff_blank");
        send("Z");
        rd(0, 0, 8'h5A, 0, "ff_z");
        chk("ff_z_cur_x", int'(cur_x), 1);

        // Repeated scrolling so the row offset wraps
        send_str("\n\n\n");
        for (int i = 0; i < 5; i++) begin
            send("k");
            send(8'h0A);
        end
        low_cycles(n);
        chk("multi_scroll_len", n, 8);
        rd(0, 0, 8'h6B, 0, "ms_r0");
        rd(0, 1, 8'h6B, 0, "ms_r1");
        rd(0, 2, 8'h6B, 0, "ms_r2");
        rd(0, 3, 8'h20, 1, "ms_r3");
        rd(1, 0, 8'h20, 0, "ms_r0c1");

        // Reset in the middle of a scroll clear
        send("m");
        send(8'h0A);
        repeat (3) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        chk_reset_vals("midreset");
        @(posedge clock); #1;
        reset = 1'b0;
        low_cycles(n);
        chk("midreset_clear_len", n, 32);
        rd(0, 0, 8'h20, 1, "midreset_cell");
        rd(0, 2, 8'h20, 0, "midreset_cell2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
